// File: rtl/ex_pkg.sv
// Shared execute-stage encodings: aluop codes, alusel result classes and the
// divider FSM states, also used by the decode stage.
package ex_pkg;

   localparam logic [7:0] OP_AND   = 8'h24;
   localparam logic [7:0] OP_OR    = 8'h25;
   localparam logic [7:0] OP_XOR   = 8'h26;
   localparam logic [7:0] OP_NOR   = 8'h27;
   localparam logic [7:0] OP_SLL   = 8'h7C;
   localparam logic [7:0] OP_SRL   = 8'h02;
   localparam logic [7:0] OP_SRA   = 8'h03;
   localparam logic [7:0] OP_ADDU  = 8'h21;
   localparam logic [7:0] OP_SUBU  = 8'h23;
   localparam logic [7:0] OP_SLT   = 8'h2A;
   localparam logic [7:0] OP_SLTU  = 8'h2B;
   localparam logic [7:0] OP_MULTU = 8'h19;
   localparam logic [7:0] OP_DIVU  = 8'h1B;
   localparam logic [7:0] OP_MFHI  = 8'h10;
   localparam logic [7:0] OP_MFLO  = 8'h12;
   localparam logic [7:0] OP_MTHI  = 8'h11;
   localparam logic [7:0] OP_MTLO  = 8'h13;

   localparam logic [2:0] SEL_LOGIC = 3'b001;
   localparam logic [2:0] SEL_SHIFT = 3'b010;
   localparam logic [2:0] SEL_ARITH = 3'b100;
   localparam logic [2:0] SEL_MOVE  = 3'b011;

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] DIV_BUSY = 2'd1;
   localparam logic [1:0] DIV_DONE = 2'd2;

   // HI/LO-only operations never write the register file.
   function automatic logic writes_gpr(input logic [7:0] op);
      return !(op == OP_MULTU || op == OP_DIVU || op == OP_MTHI || op == OP_MTLO);
   endfunction

endpackage

// File: rtl/ex_div_iter.sv
// Restoring unsigned divider, one quotient bit per cycle. A zero divisor
// naturally yields quotient all-ones and remainder equal to the dividend.
module ex_div_iter
   import ex_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            flush,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   localparam int CW = $clog2(XLEN);

   logic [1:0]      state;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] quo;
   logic [XLEN-1:0] rem;
   logic [XLEN-1:0] dsr;
   logic [XLEN:0]   shifted;
   logic [XLEN-1:0] diff;
   logic            take;

   assign shifted = {rem, quo[XLEN-1]};
   assign take    = shifted >= {1'b0, dsr};
   // When take is set the true difference is below dsr, so the low bits suffice.
   assign diff    = shifted[XLEN-1:0] - dsr;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         quo   <= '0;
         rem   <= '0;
         dsr   <= '0;
      end else if (flush) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= DIV_BUSY;
                  quo   <= dividend;
                  rem   <= '0;
                  dsr   <= divisor;
                  cnt   <= '0;
               end
            end
            DIV_BUSY: begin
               quo <= {quo[XLEN-2:0], take};
               rem <= take ? diff : shifted[XLEN-1:0];
               cnt <= cnt + 1'b1;
               if (cnt == CW'(XLEN-1)) state <= DIV_DONE;
            end
            DIV_DONE: state <= IDLE;
            default:  state <= IDLE;
         endcase
      end
   end

   assign busy      = state != IDLE;
   assign done      = state == DIV_DONE;
   assign quotient  = quo;
   assign remainder = rem;

endmodule

// File: rtl/ex_alu_mc.sv
// Execute-stage ALU: single-cycle logic/shift/arith/move results, one-cycle
// MULTU into HI/LO, and an iterative DIVU that stalls upstream until done.
module ex_alu_mc
   import ex_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               valid_i,
   input  logic [7:0]         aluop_i,
   input  logic [2:0]         alusel_i,
   input  logic [XLEN-1:0]    rdata_1_i,
   input  logic [XLEN-1:0]    rdata_2_i,
   input  logic [RADDR_W-1:0] waddr_i,
   input  logic               we_i,
   input  logic               flush_i,
   output logic               stall_o,
   output logic               valid_o,
   output logic               we_o,
   output logic [RADDR_W-1:0] waddr_o,
   output logic [XLEN-1:0]    wdata_o,
   output logic [XLEN-1:0]    hi_o,
   output logic [XLEN-1:0]    lo_o
);

   localparam int SHW = $clog2(XLEN);

   logic [XLEN-1:0]   a, b;
   logic [SHW-1:0]    sh;
   logic [XLEN-1:0]   logic_res, shift_res, arith_res, move_res, res;
   logic [2*XLEN-1:0] prod;
   logic              accept, div_start, div_done;
   logic [XLEN-1:0]   div_q, div_r;

   assign a  = rdata_1_i;
   assign b  = rdata_2_i;
   assign sh = rdata_1_i[SHW-1:0];

   assign accept    = valid_i && !stall_o && !flush_i;
   assign div_start = accept && aluop_i == OP_DIVU;
   assign prod      = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};

   always_comb begin
      logic_res = '0;
      shift_res = '0;
      arith_res = '0;
      move_res  = '0;
      case (aluop_i)
         OP_AND:  logic_res = a & b;
         OP_OR:   logic_res = a | b;
         OP_XOR:  logic_res = a ^ b;
         OP_NOR:  logic_res = ~(a | b);
         OP_SLL:  shift_res = b << sh;
         OP_SRL:  shift_res = b >> sh;
         OP_SRA:  shift_res = XLEN'($signed(b) >>> sh);
         OP_ADDU: arith_res = a + b;
         OP_SUBU: arith_res = a - b;
         OP_SLT:  arith_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
         OP_SLTU: arith_res = {{(XLEN-1){1'b0}}, a < b};
         // HI/LO are already registered, so the preceding op's write is visible.
         OP_MFHI: move_res  = hi_o;
         OP_MFLO: move_res  = lo_o;
         default: ;
      endcase
      case (alusel_i)
         SEL_LOGIC: res = logic_res;
         SEL_SHIFT: res = shift_res;
         SEL_ARITH: res = arith_res;
         SEL_MOVE:  res = move_res;
         default:   res = '0;
      endcase
   end

   ex_div_iter #(.XLEN(XLEN)) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .flush     (flush_i),
      .dividend  (a),
      .divisor   (b),
      .busy      (stall_o),
      .done      (div_done),
      .quotient  (div_q),
      .remainder (div_r)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_o <= 1'b0;
         we_o    <= 1'b0;
         waddr_o <= '0;
         wdata_o <= '0;
         hi_o    <= '0;
         lo_o    <= '0;
      end else begin
         valid_o <= 1'b0;
         we_o    <= 1'b0;
         if (!flush_i) begin
            if (div_done) begin
               valid_o <= 1'b1;
               hi_o    <= div_r;
               lo_o    <= div_q;
            end else if (accept && aluop_i != OP_DIVU) begin
               // DIVU reports only at completion; wdata/waddr hold until then.
               valid_o <= 1'b1;
               we_o    <= we_i && writes_gpr(aluop_i);
               wdata_o <= res;
               waddr_o <= waddr_i;
               case (aluop_i)
                  OP_MULTU: {hi_o, lo_o} <= prod;
                  OP_MTHI:  hi_o <= a;
                  OP_MTLO:  lo_o <= a;
                  default:  ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_ex_alu_mc.sv
// Self-checking bench for ex_alu_mc: directed vector table, multi-cycle
// sequences and randomized ops against a behavioural model.
module tb_ex_alu_mc;
   import ex_pkg::*;

   localparam int XLEN = 32;
   localparam int RW   = 5;

   logic            clk = 1'b0, rst = 1'b0;
   logic            valid_i = 1'b0, we_i = 1'b0, flush_i = 1'b0;
   logic [7:0]      aluop_i = '0;
   logic [2:0]      alusel_i = '0;
   logic [XLEN-1:0] rdata_1_i = '0, rdata_2_i = '0;
   logic [RW-1:0]   waddr_i = '0;
   logic            stall_o, valid_o, we_o;
   logic [RW-1:0]   waddr_o;
   logic [XLEN-1:0] wdata_o, hi_o, lo_o;

   ex_alu_mc #(.XLEN(XLEN), .RADDR_W(RW)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .aluop_i(aluop_i), .alusel_i(alusel_i),
      .rdata_1_i(rdata_1_i), .rdata_2_i(rdata_2_i), .waddr_i(waddr_i), .we_i(we_i),
      .flush_i(flush_i), .stall_o(stall_o), .valid_o(valid_o), .we_o(we_o),
      .waddr_o(waddr_o), .wdata_o(wdata_o), .hi_o(hi_o), .lo_o(lo_o)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0, tot = 0;

   // Architectural model state
   logic [31:0] m_hi = '0, m_lo = '0, m_wdata = '0;
   logic [4:0]  m_waddr = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tot++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] op_cls(input logic [7:0] op);
      if (op inside {OP_AND, OP_OR, OP_XOR, OP_NOR}) return SEL_LOGIC;
      if (op inside {OP_SLL, OP_SRL, OP_SRA}) return SEL_SHIFT;
      if (op inside {OP_ADDU, OP_SUBU, OP_SLT, OP_SLTU}) return SEL_ARITH;
      if (op inside {OP_MFHI, OP_MFLO}) return SEL_MOVE;
      return 3'b000;
   endfunction

   function automatic logic [31:0] ref_res(input logic [7:0] op, input logic [2:0] sel,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] hi, input logic [31:0] lo);
      logic [31:0] r;
      int sa;
      sa = int'(a % 32);
      case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_NOR:  r = ~(a | b);
         OP_SLL:  r = b << sa;
         OP_SRL:  r = b >> sa;
         OP_SRA:  r = 32'($signed(b) >>> sa);
         OP_ADDU: r = a + b;
         OP_SUBU: r = a - b;
         OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
         OP_MFHI: r = hi;
         OP_MFLO: r = lo;
         default: r = 32'd0;
      endcase
      return (sel == op_cls(op)) ? r : 32'd0;
   endfunction

   task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wa, input logic we);
      valid_i = 1'b1; aluop_i = op; alusel_i = sel;
      rdata_1_i = a; rdata_2_i = b; waddr_i = wa; we_i = we;
   endtask

   task automatic model_single(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] wa, input logic we,
                               output logic [31:0] ew, output logic ewe);
      ew  = ref_res(op, sel, a, b, m_hi, m_lo);
      ewe = we && !(op inside {OP_MULTU, OP_MTHI, OP_MTLO});
      case (op)
         OP_MULTU: {m_hi, m_lo} = 64'(a) * 64'(b);
         OP_MTHI:  m_hi = a;
         OP_MTLO:  m_lo = a;
         default:  ;
      endcase
      m_wdata = ew;
      m_waddr = wa;
   endtask

   task automatic run_single(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] wa, input logic we);
      logic [31:0] ew;
      logic        ewe;
      drive(op, sel, a, b, wa, we);
      step();
      valid_i = 1'b0;
      model_single(op, sel, a, b, wa, we, ew, ewe);
      chk($sformatf("op%0h wdata", op), 64'(wdata_o), 64'(ew));
      chk($sformatf("op%0h we", op), 64'(we_o), 64'(ewe));
      chk($sformatf("op%0h valid", op), 64'(valid_o), 64'd1);
      chk($sformatf("op%0h waddr", op), 64'(waddr_o), 64'(wa));
      chk($sformatf("op%0h hi", op), 64'(hi_o), 64'(m_hi));
      chk($sformatf("op%0h lo", op), 64'(lo_o), 64'(m_lo));
   endtask

   task automatic run_div(input logic [31:0] a, input logic [31:0] b);
      int n;
      drive(OP_DIVU, SEL_ARITH, a, b, 5'd9, 1'b1);
      step();
      valid_i = 1'b0;
      chk("div accept valid", 64'(valid_o), 64'd0);
      n = 0;
      while (stall_o === 1'b1 && n < 100) begin
         n++;
         step();
      end
      m_lo = (b == 0) ? 32'hFFFF_FFFF : a / b;
      m_hi = (b == 0) ? a : a % b;
      chk("div stall cycles", 64'(n), 64'(XLEN + 1));
      chk("div done valid", 64'(valid_o), 64'd1);
      chk("div done we", 64'(we_o), 64'd0);
      chk("div lo", 64'(lo_o), 64'(m_lo));
      chk("div hi", 64'(hi_o), 64'(m_hi));
      chk("div wdata hold", 64'(wdata_o), 64'(m_wdata));
   endtask

   typedef struct {
      logic [7:0]  op;
      logic [2:0]  sel;
      logic [31:0] a, b;
      logic [4:0]  wa;
      logic        we;
      logic [31:0] exp_w;
      logic        exp_we;
   } vec_t;

   vec_t tbl[12];
   logic [7:0] ops[19];

   initial begin
      logic [31:0] ew;
      logic        ewe;

      tbl[0]  = '{OP_OR,   SEL_LOGIC, 32'h0F0F_0000, 32'h0000_F0F0, 5'd3,  1'b1, 32'h0F0F_F0F0, 1'b1};
      tbl[1]  = '{OP_SRA,  SEL_SHIFT, 32'd4,         32'h8000_0000, 5'd4,  1'b1, 32'hF800_0000, 1'b1};
      tbl[2]  = '{OP_SLT,  SEL_ARITH, 32'hFFFF_FFFF, 32'd1,         5'd5,  1'b1, 32'd1,         1'b1};
      tbl[3]  = '{OP_SLTU, SEL_ARITH, 32'hFFFF_FFFF, 32'd1,         5'd6,  1'b1, 32'd0,         1'b1};
      tbl[4]  = '{OP_ADDU, SEL_ARITH, 32'hFFFF_FFFF, 32'd2,         5'd7,  1'b1, 32'd1,         1'b1};
      tbl[5]  = '{OP_SUBU, SEL_ARITH, 32'd0,         32'd1,         5'd8,  1'b1, 32'hFFFF_FFFF, 1'b1};
      tbl[6]  = '{OP_NOR,  SEL_LOGIC, 32'h0F0F_0F0F, 32'hF0F0_0000, 5'd9,  1'b1, 32'h0000_F0F0, 1'b1};
      tbl[7]  = '{OP_SLL,  SEL_SHIFT, 32'h0000_0024, 32'h1234_5678, 5'd10, 1'b1, 32'h2345_6780, 1'b1};
      tbl[8]  = '{OP_ADDU, SEL_LOGIC, 32'd1,         32'd2,         5'd11, 1'b1, 32'd0,         1'b1};
      tbl[9]  = '{8'h55,   SEL_LOGIC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 1'b1, 32'd0,         1'b1};
      tbl[10] = '{OP_SRL,  SEL_SHIFT, 32'd31,        32'h8000_0000, 5'd13, 1'b1, 32'd1,         1'b1};
      tbl[11] = '{OP_AND,  SEL_LOGIC, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd14, 1'b0, 32'h0F00_0F00, 1'b0};

      ops = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA, OP_ADDU, OP_SUBU,
              OP_SLT, OP_SLTU, OP_MULTU, OP_DIVU, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO,
              8'h55, 8'h00};

      // Reset state
      step(); step();
      chk("rst valid", 64'(valid_o), 64'd0);
      chk("rst we", 64'(we_o), 64'd0);
      chk("rst wdata", 64'(wdata_o), 64'd0);
      chk("rst waddr", 64'(waddr_o), 64'd0);
      chk("rst hilo", {hi_o, lo_o}, 64'd0);
      chk("rst stall", 64'(stall_o), 64'd0);
      rst = 1'b1;
      step();

      // Directed vector table
      foreach (tbl[i]) begin
         drive(tbl[i].op, tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].wa, tbl[i].we);
         step();
         valid_i = 1'b0;
         model_single(tbl[i].op, tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].wa, tbl[i].we, ew, ewe);
         chk($sformatf("vec%0d wdata", i), 64'(wdata_o), 64'(tbl[i].exp_w));
         chk($sformatf("vec%0d we", i), 64'(we_o), 64'(tbl[i].exp_we));
         chk($sformatf("vec%0d valid", i), 64'(valid_o), 64'd1);
         chk($sformatf("vec%0d waddr", i), 64'(waddr_o), 64'(tbl[i].wa));
      end

      // Idle cycle holds data, drops valid/we
      step();
      chk("idle valid", 64'(valid_o), 64'd0);
      chk("idle we", 64'(we_o), 64'd0);
      chk("idle wdata", 64'(wdata_o), 64'(m_wdata));
      chk("idle waddr", 64'(waddr_o), 64'(m_waddr));

      // MULTU then forwarded MFHI/MFLO
      run_single(OP_MULTU, SEL_ARITH, 32'hFFFF_FFFF, 32'd2, 5'd1, 1'b1);
      chk("multu hi", 64'(hi_o), 64'd1);
      chk("multu lo", 64'(lo_o), 64'hFFFF_FFFE);
      run_single(OP_MFHI, SEL_MOVE, 32'd0, 32'd0, 5'd2, 1'b1);
      chk("mfhi fwd", 64'(wdata_o), 64'd1);
      run_single(OP_MFLO, SEL_MOVE, 32'd0, 32'd0, 5'd2, 1'b1);
      chk("mflo fwd", 64'(wdata_o), 64'hFFFF_FFFE);
      run_single(OP_MTHI, SEL_MOVE, 32'hCAFE_0001, 32'd0, 5'd3, 1'b1);
      run_single(OP_MFHI, SEL_MOVE, 32'd0, 32'd0, 5'd4, 1'b1);
      chk("mthi fwd", 64'(wdata_o), 64'hCAFE_0001);
      run_single(OP_MTLO, SEL_MOVE, 32'hBEEF_0002, 32'd0, 5'd3, 1'b1);

      // Divides
      run_div(32'd100, 32'd7);
      chk("div 100/7 lo", 64'(lo_o), 64'd14);
      chk("div 100/7 hi", 64'(hi_o), 64'd2);
      run_div(32'd5, 32'd0);
      chk("div0 lo", 64'(lo_o), 64'hFFFF_FFFF);
      chk("div0 hi", 64'(hi_o), 64'd5);

      // Flush at cycle 10 of a divide
      drive(OP_DIVU, SEL_ARITH, 32'd1000, 32'd3, 5'd1, 1'b1);
      step();
      valid_i = 1'b0;
      repeat (9) step();
      chk("flush pre stall", 64'(stall_o), 64'd1);
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      chk("flush stall", 64'(stall_o), 64'd0);
      chk("flush valid", 64'(valid_o), 64'd0);
      chk("flush hi", 64'(hi_o), 64'(m_hi));
      chk("flush lo", 64'(lo_o), 64'(m_lo));
      step();
      chk("flush stays idle", 64'(stall_o), 64'd0);

      // Flush together with valid discards the op
      drive(OP_ADDU, SEL_ARITH, 32'd1, 32'd1, 5'd20, 1'b1);
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      valid_i = 1'b0;
      chk("flush+valid valid", 64'(valid_o), 64'd0);
      chk("flush+valid we", 64'(we_o), 64'd0);
      chk("flush+valid wdata", 64'(wdata_o), 64'(m_wdata));

      // Randomized ops against the model
      for (int it = 0; it < 150; it++) begin
         logic [7:0]  op;
         logic [2:0]  sel;
         logic [31:0] a, b;
         op = ops[$urandom_range(0, 18)];
         sel = ($urandom_range(0, 1) == 0) ? op_cls(op) : 3'($urandom_range(0, 7));
         a = $urandom();
         b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom();
         if (op == OP_DIVU) begin
            run_div(a, b);
         end else if ($urandom_range(0, 4) == 0) begin
            valid_i = 1'b0; aluop_i = op; rdata_1_i = a; rdata_2_i = b;
            waddr_i = 5'($urandom()); we_i = 1'b1;
            step();
            chk("rnd idle valid", 64'(valid_o), 64'd0);
            chk("rnd idle we", 64'(we_o), 64'd0);
            chk("rnd idle wdata", 64'(wdata_o), 64'(m_wdata));
            chk("rnd idle waddr", 64'(waddr_o), 64'(m_waddr));
         end else begin
            run_single(op, sel, a, b, 5'($urandom()), 1'($urandom()));
         end
      end

      // Reset at cycle 10 of a divide
      drive(OP_DIVU, SEL_ARITH, 32'd77, 32'd5, 5'd1, 1'b1);
      step();
      valid_i = 1'b0;
      repeat (9) step();
      rst = 1'b0;
      step();
      chk("rst mid valid", 64'(valid_o), 64'd0);
      chk("rst mid we", 64'(we_o), 64'd0);
      chk("rst mid wdata", 64'(wdata_o), 64'd0);
      chk("rst mid waddr", 64'(waddr_o), 64'd0);
      chk("rst mid hilo", {hi_o, lo_o}, 64'd0);
      chk("rst mid stall", 64'(stall_o), 64'd0);
      rst = 1'b1;
      repeat (40) step();
      chk("post rst hilo", {hi_o, lo_o}, 64'd0);
      chk("post rst valid", 64'(valid_o), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, tot);
      $finish;
   end

endmodule

// File: doc/ex_alu_mc.md
EX_ALU_MC -- requirements
Module: ex_alu_mc

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning datapath width in bits.
REQ-002 The block SHALL have parameter RADDR_W, default 5, meaning register-address width.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 valid_i  input  1  operation present this cycle.
REQ-006 aluop_i  input  8  operation code.
REQ-007 alusel_i  input  3  result class: 001 logic, 010 shift, 100 arith, 011 move, others none.
REQ-008 rdata_1_i, rdata_2_i  input  XLEN each  operands A and B.
REQ-009 waddr_i  input  RADDR_W  destination register; we_i  input  1  write enable.
REQ-010 flush_i  input  1  abort in-flight and presented operations.
REQ-011 stall_o  output  1  block busy; upstream SHALL hold its inputs.
REQ-012 valid_o, we_o  output  1 each; waddr_o  output  RADDR_W; wdata_o  output  XLEN  registered result.
REQ-013 hi_o, lo_o  output  XLEN each  architectural HI/LO registers.

Function
REQ-014 Opcodes: AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SLL 0x7C, SRL 0x02, SRA 0x03, ADDU 0x21, SUBU 0x23, SLT 0x2A, SLTU 0x2B, MULTU 0x19, DIVU 0x1B, MFHI 0x10, MFLO 0x12, MTHI 0x11, MTLO 0x13; any other opcode gives result 0.
REQ-015 An operation is accepted on a rising edge with valid_i=1, stall_o=0 and flush_i=0.
REQ-016 Single-cycle operations: the registered outputs for an operation accepted at edge N SHALL be valid after edge N; latency is 1 cycle.
REQ-017 Shifts SHALL use A[log2(XLEN)-1:0] as the shift amount and B as the data.
REQ-018 ADDU and SUBU SHALL wrap modulo 2^XLEN with no overflow flag.
REQ-019 SLT SHALL return 1 when A<B as signed values; SLTU SHALL return 1 when A<B as unsigned values.
REQ-020 wdata_o SHALL select the result of the class named by alusel_i; when the class does not match the opcode, wdata_o SHALL be 0.
REQ-021 MULTU SHALL compute in one cycle and write {hi,lo} = A*B (2*XLEN bits); we_o SHALL be 0 for MULTU.
REQ-022 MTHI and MTLO SHALL write A to HI and LO respectively; we_o SHALL be 0 for these operations.
REQ-023 MFHI and MFLO SHALL return the current HI or LO, including a value written by the immediately preceding operation (forwarded).
REQ-024 DIVU SHALL use a restoring divider with FSM states IDLE -> DIV_BUSY -> DIV_DONE -> IDLE, one quotient bit per cycle, XLEN iterations.
REQ-025 When DIVU is accepted at edge N, stall_o SHALL be 1 from edge N until edge N+XLEN+1.
REQ-026 In DIV_DONE, the block SHALL write LO=quotient and HI=remainder; valid_o=1 and we_o=0 for one cycle; stall_o falls and the FSM returns to IDLE.
REQ-027 Divide by zero: DIVU with B=0 SHALL give LO=all-ones and HI=A, with the same latency as a normal divide.
REQ-028 flush_i=1 SHALL return the FSM to IDLE, deassert stall_o, and leave HI/LO unchanged.
REQ-029 When flush_i=1, the block SHALL force valid_o=0 and we_o=0 on the next edge.
REQ-030 When valid_i=0 or not accepted, the block SHALL force valid_o=0 and we_o=0 on the next edge; wdata_o and waddr_o SHALL hold their previous values.
REQ-031 When flush_i=1 and valid_i=1 arrive together, flush SHALL win and the operation SHALL be discarded.

Reset
REQ-032 While rst=0 at a rising edge, the block SHALL clear wdata_o, waddr_o, we_o, valid_o, hi_o, lo_o and all divider registers to 0.
REQ-033 While rst=0 at a rising edge, the FSM SHALL be IDLE and stall_o SHALL be 0.
REQ-034 Reset during DIV_BUSY SHALL abort the divide, and HI/LO SHALL read 0 afterwards.

Structure
REQ-035 The aluop codes, alusel codes and FSM state encoding SHALL reside in a shared package ex_pkg, reused by the decode stage.
REQ-036 The divider SHALL be a sub-module ex_div_iter with parameter XLEN and a start/busy/done handshake; all other logic SHALL stay in ex_alu_mc.

Verification
REQ-037 The bench SHALL cover OR: A=0x0F0F_0000, B=0x0000_F0F0, alusel=001, waddr=3, we=1 -> next cycle wdata=0x0F0F_F0F0, waddr=3, we=1, valid=1.
REQ-038 The bench SHALL cover shift and compare: SRA with A=4, B=0x8000_0000 -> 0xF800_0000; SLT with A=0xFFFF_FFFF, B=1 -> 1; SLTU with the same operands -> 0.
REQ-039 The bench SHALL cover MULTU forwarding: MULTU with A=0xFFFF_FFFF, B=2, then MFHI -> wdata=1; then MFLO -> 0xFFFF_FFFE.
REQ-040 The bench SHALL cover DIVU: A=100, B=7 -> stall_o high for exactly 33 cycles, then LO=14, HI=2, we_o=0.
REQ-041 The bench SHALL cover divide by zero: DIVU with A=5, B=0 -> LO=0xFFFF_FFFF, HI=5 after 33 cycles.
REQ-042 The bench SHALL cover abort: flush_i at cycle 10 of a DIVU -> stall_o=0 on the next edge with HI/LO unchanged; rst=0 at cycle 10 -> all outputs 0.
